// File: rtl/pool_engine_if.sv
// Bus bundle between the pooling engine and its DRAM/host side.
interface pool_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                  enable;
  logic                  dram_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  dram_en_rd;
  logic                  dram_en_wr;
  logic                  done;

  modport slave (
    input  enable, dram_valid, data_in,
    output data_out, addr_in, addr_out, dram_en_rd, dram_en_wr, done
  );

  modport master (
    output enable, dram_valid, data_in,
    input  data_out, addr_in, addr_out, dram_en_rd, dram_en_wr, done
  );
endinterface

// File: rtl/pool_engine.sv
// DRAM-to-DRAM KxK pooling engine (K in {1,2,4}, signed max or average).
// Every register advances only on accepted cycles (dram_valid = 1).
module pool_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int X_BITS     = 5,
  parameter int Y_BITS     = 5,
  parameter int Z_BITS     = 4,
  parameter int PARAM_BASE = 0,
  parameter int OFMAP_BASE = 65536,
  parameter int IFMAP_BASE = 131072
) (
  input  logic           clk,
  input  logic           srst,
  pool_engine_if.slave   bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + 4;
  localparam int PW = Z_BITS + Y_BITS + X_BITS;
  localparam logic [DW-1:0] ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PRM_A = ADDR_WIDTH'(PARAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] OFM_A = ADDR_WIDTH'(OFMAP_BASE);
  localparam logic [ADDR_WIDTH-1:0] IFM_A = ADDR_WIDTH'(IFMAP_BASE);

  typedef enum logic [2:0] {S_IDLE, S_LD, S_POOL, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            pcnt_q;
  logic [DW-1:0]         d_q, h_q, w_q, oh_q, ow_q;
  logic [1:0]            lk_q;
  logic                  mode_q;
  logic [DW-1:0]         z_q, oy_q, ox_q;
  logic [1:0]            dy_q, dx_q;
  logic                  drn_q;
  logic                  p1_vld_q, p1_first_q, p1_last_q;
  logic [PW-1:0]         p1_waddr_q;
  logic signed [AW-1:0]  acc_q;
  logic [DW-1:0]         dout_q;
  logic [ADDR_WIDTH-1:0] aout_q;
  logic                  wr_q;

  logic                  acc_en;
  logic [1:0]            km1, lk_new;
  logic [DW-1:0]         k_new;
  logic                  skip;
  logic                  last_dx, last_dy, last_ox, last_oy, last_z, win_last;
  logic [PW-1:0]         rd_pack;
  logic signed [AW-1:0]  din_x, acc_nx;
  logic [DW-1:0]         res;

  assign acc_en = bus.dram_valid;

  // Window geometry and the packed read address for the current scan position.
  always_comb begin
    km1      = (lk_q == 2'd2) ? 2'd3 : (lk_q == 2'd1) ? 2'd1 : 2'd0;
    last_dx  = (dx_q == km1);
    last_dy  = (dy_q == km1);
    last_ox  = (ox_q == ow_q - ONE);
    last_oy  = (oy_q == oh_q - ONE);
    last_z   = (z_q == d_q - ONE);
    win_last = last_dx && last_dy;
    rd_pack  = {z_q[Z_BITS-1:0],
                Y_BITS'((oy_q << lk_q) + DW'(dy_q)),
                X_BITS'((ox_q << lk_q) + DW'(dx_q))};
    // Config word 3 decode; log2K = 3 degrades to K = 1.
    lk_new   = (bus.data_in[1:0] == 2'd3) ? 2'd0 : bus.data_in[1:0];
    k_new    = ONE << lk_new;
    skip     = (d_q == '0) || (h_q < k_new) || (w_q < k_new);
  end

  // Accumulator combine: first pixel loads, then sum or signed max (tie keeps earlier).
  always_comb begin
    din_x = {{4{bus.data_in[DW-1]}}, bus.data_in};
    if (p1_first_q)  acc_nx = din_x;
    else if (mode_q) acc_nx = acc_q + din_x;
    else             acc_nx = (din_x > acc_q) ? din_x : acc_q;
    res = mode_q ? DW'(acc_nx >>> {lk_q, 1'b0}) : acc_nx[DW-1:0];
  end

  // Next-state logic; a stall freezes the state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.enable) state_d = S_LD;
      S_LD:    if (pcnt_q == 3'd4) state_d = skip ? S_DONE : S_POOL;
      S_POOL:  if (win_last && last_ox && last_oy && last_z) state_d = S_DRAIN;
      S_DRAIN: if (drn_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!acc_en) state_d = state_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Config capture and scan counters (z, oy, ox, dy, dx).
  always_ff @(posedge clk) begin
    if (srst) begin
      pcnt_q <= '0; d_q <= '0; h_q <= '0; w_q <= '0; oh_q <= '0; ow_q <= '0;
      lk_q <= '0; mode_q <= 1'b0; z_q <= '0; oy_q <= '0; ox_q <= '0;
      dy_q <= '0; dx_q <= '0; drn_q <= 1'b0;
    end else if (acc_en) begin
      unique case (state_q)
        S_IDLE: begin
          pcnt_q <= '0;
          drn_q  <= 1'b0;
        end
        S_LD: begin
          pcnt_q <= pcnt_q + 3'd1;
          // Read data lags its address by one accepted cycle.
          unique case (pcnt_q)
            3'd1: d_q <= bus.data_in;
            3'd2: h_q <= bus.data_in;
            3'd3: w_q <= bus.data_in;
            3'd4: begin
              lk_q   <= lk_new;
              mode_q <= bus.data_in[2];
              ow_q   <= w_q >> lk_new;
              oh_q   <= h_q >> lk_new;
              z_q <= '0; oy_q <= '0; ox_q <= '0; dy_q <= '0; dx_q <= '0;
            end
            default: ;
          endcase
        end
        S_POOL: begin
          if (!last_dx) dx_q <= dx_q + 2'd1;
          else begin
            dx_q <= '0;
            if (!last_dy) dy_q <= dy_q + 2'd1;
            else begin
              dy_q <= '0;
              if (!last_ox) ox_q <= ox_q + ONE;
              else begin
                ox_q <= '0;
                if (!last_oy) oy_q <= oy_q + ONE;
                else begin
                  oy_q <= '0;
                  z_q  <= z_q + ONE;
                end
              end
            end
          end
        end
        S_DRAIN: drn_q <= ~drn_q;
        default: ;
      endcase
    end
  end

  // Read-return pipeline: tag each read, fold returned pixel, register the write.
  always_ff @(posedge clk) begin
    if (srst) begin
      p1_vld_q <= 1'b0; p1_first_q <= 1'b0; p1_last_q <= 1'b0; p1_waddr_q <= '0;
      acc_q <= '0; dout_q <= '0; aout_q <= '0; wr_q <= 1'b0;
    end else if (acc_en) begin
      p1_vld_q   <= (state_q == S_POOL);
      p1_first_q <= (dx_q == 2'd0) && (dy_q == 2'd0);
      p1_last_q  <= win_last;
      p1_waddr_q <= {z_q[Z_BITS-1:0], oy_q[Y_BITS-1:0], ox_q[X_BITS-1:0]};
      if (p1_vld_q) acc_q <= acc_nx;
      wr_q <= p1_vld_q && p1_last_q;
      if (p1_vld_q && p1_last_q) begin
        dout_q <= res;
        aout_q <= OFM_A + ADDR_WIDTH'(p1_waddr_q);
      end
    end
  end

  // Outputs: read/write strobes and done are masked during a stall.
  always_comb begin
    bus.addr_in = '0;
    if (state_q == S_POOL)    bus.addr_in = IFM_A + ADDR_WIDTH'(rd_pack);
    else if (state_q == S_LD) bus.addr_in = PRM_A + ADDR_WIDTH'(pcnt_q);
    bus.dram_en_rd = acc_en && (((state_q == S_LD) && (pcnt_q < 3'd4)) || (state_q == S_POOL));
    bus.dram_en_wr = acc_en && wr_q;
    bus.done       = acc_en && (state_q == S_DONE);
    bus.data_out   = dout_q;
    bus.addr_out   = aout_q;
  end
endmodule

// File: tb/tb_pool_engine.sv
// Scoreboard bench for pool_engine: stimulus pushes expected reads/writes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pool_engine;
  localparam int DW  = 32;
  localparam int AWD = 18;
  localparam int IFM = 131072;
  localparam int OFM = 65536;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  pool_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) bus ();
  pool_engine dut (.clk(clk), .srst(srst), .bus(bus.slave));

  typedef struct packed {
    logic [AWD-1:0] a;
    logic [DW-1:0]  d;
  } wr_t;

  logic [DW-1:0]  mem [int];
  wr_t            exp_wr [$];
  logic [AWD-1:0] exp_rd [$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  bit stall_wr = 1'b0;

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // DRAM model: data for an accepted read shows up on the next cycle and holds.
  always @(posedge clk)
    if (bus.dram_valid && bus.dram_en_rd)
      bus.data_in <= mem.exists(int'(bus.addr_in)) ? mem[int'(bus.addr_in)] : '0;

  // Monitor: compares every accepted pool read and every write against the queues.
  always @(negedge clk) begin
    if (!srst) begin
      if (bus.dram_en_wr && !bus.dram_valid) stall_wr = 1'b1;
      if (bus.dram_en_wr && bus.dram_valid) begin
        wr_t e;
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0d, expected none", bus.addr_out);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", longint'(bus.addr_out), longint'(e.a));
          chk("wr_data", longint'($signed(bus.data_out)), longint'($signed(e.d)));
        end
      end
      if (bus.dram_en_rd && bus.dram_valid && int'(bus.addr_in) >= IFM) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got addr %0d, expected none", bus.addr_in);
        end else
          chk("rd_addr", longint'(bus.addr_in), longint'(exp_rd.pop_front()));
      end
    end
  end

  function automatic int pa(int z, int y, int x);
    return IFM + z * 1024 + y * 32 + x;
  endfunction

  task automatic set_cfg(input int d, input int h, input int w, input int lk, input int mode);
    mem[0] = d; mem[1] = h; mem[2] = w; mem[3] = lk | (mode << 2);
  endtask

  // Hand-written 4x4 map used by the directed max/average cases.
  task automatic fill_t1();
    int px [16] = '{-5, -1, 4, 5,  -7, -3, 6, 7,  -3, -2, 1, 2,  0, 0, 3, 9};
    for (int i = 0; i < 16; i++) mem[pa(0, i / 4, i % 4)] = px[i];
  endtask

  task automatic fill_fmt(input int d, input int h, input int w);
    for (int z = 0; z < d; z++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          mem[pa(z, y, x)] = ((z * 7 + y * 13 + x * 5) % 23) - 11;
  endtask

  // Reference pooling: walks windows in scan order, queues reads and (optionally) results.
  task automatic model(input int d, input int h, input int w, input int lk, input int mode,
                       input bit push_wr);
    int k;
    longint acc, v;
    wr_t e;
    k = 1 << lk;
    for (int z = 0; z < d; z++)
      for (int oy = 0; oy < h / k; oy++)
        for (int ox = 0; ox < w / k; ox++) begin
          acc = 0;
          for (int dy = 0; dy < k; dy++)
            for (int dx = 0; dx < k; dx++) begin
              exp_rd.push_back(AWD'(pa(z, oy * k + dy, ox * k + dx)));
              v = longint'($signed(mem[pa(z, oy * k + dy, ox * k + dx)]));
              if (dy == 0 && dx == 0) acc = v;
              else if (mode != 0)     acc = acc + v;
              else if (v > acc)       acc = v;
            end
          if (mode != 0) acc = acc >>> (2 * lk);
          e.a = AWD'(OFM + z * 1024 + oy * 32 + ox);
          e.d = acc[DW-1:0];
          if (push_wr) exp_wr.push_back(e);
        end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.a = AWD'(a);
    e.d = d;
    exp_wr.push_back(e);
  endtask

  function automatic bit vpat(int c);
    return !((c >= 9 && c <= 11) || (c > 12 && (c % 4) == 1));
  endfunction

  // Starts a run, waits (bounded) for done, then checks write count and drained queues.
  task automatic go(input string n, input int exp_n, input bit stall);
    int  w0;
    bit  seen;
    w0   = wr_cnt;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      bus.enable     = (c == 0);
      bus.dram_valid = (stall && c > 0) ? vpat(c) : 1'b1;
      @(negedge clk);
      if (bus.done && bus.dram_valid) seen = 1'b1;
    end
    @(posedge clk); #1;
    bus.dram_valid = 1'b1;
    bus.enable     = 1'b0;
    chk({n, "_done"}, longint'(seen), 1);
    chk({n, "_writes"}, longint'(wr_cnt - w0), longint'(exp_n));
    chk({n, "_wq_empty"}, longint'(exp_wr.size()), 0);
    chk({n, "_rq_empty"}, longint'(exp_rd.size()), 0);
    exp_wr.delete();
    exp_rd.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic push_t1_max();
    push_wr(65536, -1); push_wr(65537, 7); push_wr(65568, 0); push_wr(65569, 9);
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.dram_valid = 1'b1;
    srst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    chk("rst_en_rd", longint'(bus.dram_en_rd), 0);
    chk("rst_en_wr", longint'(bus.dram_en_wr), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_addr_in", longint'(bus.addr_in), 0);
    chk("rst_addr_out", longint'(bus.addr_out), 0);
    chk("rst_data_out", longint'(bus.data_out), 0);

    // 1: 4x4, K=2, max, negative pixels.
    fill_t1(); set_cfg(1, 4, 4, 1, 0);
    model(1, 4, 4, 1, 0, 1'b0);
    push_t1_max();
    go("t1_max", 4, 1'b0);

    // 2: same map, average (floor on negative sums).
    set_cfg(1, 4, 4, 1, 1);
    model(1, 4, 4, 1, 1, 1'b0);
    push_wr(65536, -4); push_wr(65537, 5); push_wr(65568, -2); push_wr(65569, 3);
    go("t2_avg", 4, 1'b0);

    // 3: two channels, 8x8, K=4, max.
    fill_fmt(2, 8, 8); set_cfg(2, 8, 8, 2, 0);
    model(2, 8, 8, 2, 0, 1'b1);
    go("t3_k4", 8, 1'b0);

    // 4: odd dimensions, trailing row/column skipped.
    fill_fmt(1, 5, 7); set_cfg(1, 5, 7, 1, 1);
    model(1, 5, 7, 1, 1, 1'b1);
    go("t4_odd", 6, 1'b0);

    // 5: stalls mid-window and on write cycles; results must match run 1.
    fill_t1(); set_cfg(1, 4, 4, 1, 0);
    model(1, 4, 4, 1, 0, 1'b0);
    push_t1_max();
    go("t5_stall", 4, 1'b1);
    chk("t5_no_wr_in_stall", longint'(stall_wr), 0);

    // log2K = 3 behaves as K = 1: every pixel copied through.
    set_cfg(1, 2, 2, 3, 0);
    model(1, 2, 2, 0, 0, 1'b0);
    push_wr(65536, -5); push_wr(65537, -1); push_wr(65568, -7); push_wr(65569, -3);
    go("t6_k1", 4, 1'b0);

    // 6a: H < K -> done with no writes.
    set_cfg(1, 1, 4, 1, 0);
    go("t6_degen", 0, 1'b0);

    // 6b: reset in the middle of POOL, then a clean run.
    fill_fmt(2, 8, 8); set_cfg(2, 8, 8, 2, 0);
    model(2, 8, 8, 2, 0, 1'b0);
    @(posedge clk); #1 bus.enable = 1'b1;
    @(posedge clk); #1 bus.enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk);
    exp_rd.delete();
    chk("srst_en_rd", longint'(bus.dram_en_rd), 0);
    chk("srst_en_wr", longint'(bus.dram_en_wr), 0);
    chk("srst_done", longint'(bus.done), 0);
    chk("srst_addr_in", longint'(bus.addr_in), 0);
    chk("srst_addr_out", longint'(bus.addr_out), 0);
    chk("srst_data_out", longint'(bus.data_out), 0);
    fill_t1(); set_cfg(1, 4, 4, 1, 0);
    model(1, 4, 4, 1, 0, 1'b0);
    push_t1_max();
    go("t6_after_srst", 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
